nfc_picc_responder: RTL
=======================

Name: nfc_picc_responder

Overview:
Synthesizable responder for the card-detector command interface (valid/ready/write/addr/wdata/rdata/done). It emulates the MFRC522 front end plus one ISO14443A Type-A card: it raises the card IRQ, answers REQA/WUPA/ANTICOLL/SELECT/HLTA, and serves UID bytes. It sits opposite nfc_card_detector as an in-system loopback target and as the reusable bench model for that detector.

Parameters:
RESP_DELAY, 5, cycles from command accept to done pulse; legal range 1..255.
IRQ_PULSE, 10, length in cycles of the nfc_irq pulse on card arrival; legal range 1..255.
ATQA_LO, 8'h04, byte returned for REQA/WUPA.
SAK_VALUE, 8'h08, byte returned on successful SELECT.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
card_present  in  1  card in field (synchronous to clk)
card_uid  in  32  UID of arriving card, sampled on card_present rising edge
nfc_irq  out  1  card-arrival interrupt pulse
nfc_cmd_valid  in  1  command request
nfc_cmd_ready  out  1  responder can accept a command
nfc_cmd_write  in  1  1 = write/command, 0 = read
nfc_cmd_addr  in  6  register address
nfc_cmd_wdata  in  8  command/write byte
nfc_cmd_rdata  out  8  response byte, valid in the done cycle
nfc_cmd_done  out  1  one-cycle completion pulse
cmd_error  out  1  one-cycle pulse coincident with done when the response is an error
picc_state  out  3  0 OFF, 1 IDLE, 2 READY, 3 ACTIVE, 4 HALT

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: nfc_cmd_ready=1, nfc_cmd_done=0, nfc_cmd_rdata=0, nfc_irq=0, cmd_error=0, picc_state=OFF, uid=0, uid_sent=0, rd_ptr=0, counters=0.
- Card arrival (card_present 0->1, edge detected with a registered copy):
  - latch card_uid, set state IDLE, clear uid_sent and rd_ptr;
  - drive nfc_irq=1 for exactly IRQ_PULSE cycles starting the next cycle;
  - a new arrival during an active pulse restarts the pulse.
- Card removal (1->0): state OFF immediately; nfc_irq deasserts.
- Handshake:
  - A command is accepted when valid&&ready. ready=0 from the next cycle.
  - write/addr/wdata are latched at accept; inputs are ignored while busy.
  - After RESP_DELAY cycles, done=1 for one cycle with rdata valid. ready returns to 1 in that same cycle.
  - Back-to-back accept is allowed in the cycle after done.
- Decoding:
  - Write with addr!=6'h09: plain register write, rdata=0x00, no state change.
  - Read with addr==6'h09: returns uid byte rd_ptr (byte0=uid[7:0] .. byte3=uid[31:24]), then BCC (XOR of the 4 bytes) at rd_ptr=4; rd_ptr then wraps to 0.
  - Read at any other addr returns 0x00.
- Card commands (write to addr 6'h09, wdata = command):
  - 0x26 REQA: IDLE->READY, rdata=ATQA_LO.
  - 0x52 WUPA: IDLE or HALT -> READY, rdata=ATQA_LO.
  - 0x93 in READY with uid_sent=0: rdata=uid[7:0], uid_sent=1, rd_ptr=1, state stays READY.
  - 0x93 in READY with uid_sent=1: state ACTIVE, rdata=SAK_VALUE, uid_sent=0.
  - 0x50 HLTA in ACTIVE: state HALT, rdata=0x00.
  - Any other byte or state combination (including any command in OFF, or REQA in HALT): rdata=0xFF, cmd_error=1, state unchanged.
- State transitions take effect in the done cycle. The decode uses the state present at the done cycle.
- Simultaneous events:
  - An arrival edge in the same cycle as done is applied first; the command then decodes against IDLE.
  - Removal while busy: the command still completes with rdata=0xFF, cmd_error=1, and state OFF.
- Reset mid-command: all outputs return to reset values immediately; the pending command is discarded with no done pulse.

Test Plan:
- Reset check: rst_n low -> ready=1, done=0, irq=0, picc_state=0. card_present 0->1 with uid 0x12345678 -> irq high 10 cycles, state=1.
- Full select: REQA 0x26 -> done 5 cycles after accept, rdata 0x04, state 2. First 0x93 -> rdata 0x78. Second 0x93 -> rdata 0x08, state 3. Repeat against nfc_card_detector -> card_uid reflects 0x78, no detection_error.
- UID reads after first 0x93: five reads of addr 0x09 -> 0x56, 0x34, 0x12, BCC 0x08, then 0x78 (wrap).
- HLTA 0x50 in ACTIVE -> state 4. REQA -> rdata 0xFF, cmd_error=1. WUPA 0x52 -> rdata 0x04, state 2.
- Error paths: 0x93 in IDLE -> 0xFF+error. Any command with no card -> 0xFF+error. Write to addr 0x01 -> rdata 0x00, no state change.
- Corner cases: card_present dropped 2 cycles after accept -> done with 0xFF, state 0. rst_n pulsed mid-command -> no done pulse, ready=1. Second arrival with uid 0xCAFEBABE -> state IDLE; after REQA, first 0x93 returns 0xBE.

Source files
------------

// File: rtl/nfc_picc_responder.sv
// nfc_picc_responder: MFRC522 front end plus one ISO14443A card answering the detector command interface
module nfc_picc_responder #(
   parameter int unsigned RESP_DELAY = 5,
   parameter int unsigned IRQ_PULSE  = 10,
   parameter logic [7:0]  ATQA_LO    = 8'h04,
   parameter logic [7:0]  SAK_VALUE  = 8'h08
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_present,
   input  logic [31:0] card_uid,
   output logic        nfc_irq,
   input  logic        nfc_cmd_valid,
   output logic        nfc_cmd_ready,
   input  logic        nfc_cmd_write,
   input  logic [5:0]  nfc_cmd_addr,
   input  logic [7:0]  nfc_cmd_wdata,
   output logic [7:0]  nfc_cmd_rdata,
   output logic        nfc_cmd_done,
   output logic        cmd_error,
   output logic [2:0]  picc_state
);
   typedef enum logic [2:0] {ST_OFF = 3'd0, ST_IDLE = 3'd1, ST_READY = 3'd2, ST_ACTIVE = 3'd3, ST_HALT = 3'd4} state_t;
   state_t      r_state, w_st_eff, w_nstate;
   logic        r_card_q, r_uid_sent, r_busy, r_write, r_done, r_err;
   logic [31:0] r_uid, w_uid_eff;
   logic [2:0]  r_rd_ptr, w_ptr_eff, w_nptr;
   logic [7:0]  r_irq_cnt, r_dly_cnt, r_wdata, r_rdata, w_rdata, w_rd_byte, w_bcc;
   logic [5:0]  r_addr;
   logic        w_arrive, w_remove, w_fire, w_accept, w_sent_eff, w_nsent, w_err;
   assign w_arrive   = card_present & ~r_card_q;
   assign w_remove   = ~card_present & r_card_q;
   assign w_fire     = r_busy && (r_dly_cnt == 8'd1);
   assign w_accept   = nfc_cmd_valid && !r_busy;
   // a card event in the done cycle is applied before the command decodes
   assign w_st_eff   = w_arrive ? ST_IDLE : (w_remove ? ST_OFF : r_state);
   assign w_uid_eff  = w_arrive ? card_uid : r_uid;
   assign w_sent_eff = w_arrive ? 1'b0 : r_uid_sent;
   assign w_ptr_eff  = w_arrive ? 3'd0 : r_rd_ptr;
   assign w_bcc      = w_uid_eff[7:0] ^ w_uid_eff[15:8] ^ w_uid_eff[23:16] ^ w_uid_eff[31:24];
   assign w_rd_byte  = (w_ptr_eff == 3'd0) ? w_uid_eff[7:0]   :
                       (w_ptr_eff == 3'd1) ? w_uid_eff[15:8]  :
                       (w_ptr_eff == 3'd2) ? w_uid_eff[23:16] :
                       (w_ptr_eff == 3'd3) ? w_uid_eff[31:24] : w_bcc;
   assign nfc_cmd_ready = ~r_busy;
   assign nfc_cmd_done  = r_done;
   assign nfc_cmd_rdata = r_rdata;
   assign cmd_error     = r_err;
   assign nfc_irq       = (r_irq_cnt != 8'd0);
   assign picc_state    = r_state;
   // card state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_OFF;
      else        r_state <= w_nstate;
   end
   // next card state and response byte, decoded only in the done cycle
   always_comb begin
      w_nstate = w_st_eff;
      w_nsent  = w_sent_eff;
      w_nptr   = w_ptr_eff;
      w_rdata  = 8'h00;
      w_err    = 1'b0;
      if (w_fire) begin
         if (!r_write) begin
            if (r_addr == 6'h09) begin
               w_rdata = w_rd_byte;
               w_nptr  = (w_ptr_eff >= 3'd4) ? 3'd0 : w_ptr_eff + 3'd1;
            end
         end else if (r_addr == 6'h09) begin
            w_rdata = 8'hFF;
            w_err   = 1'b1;
            case (r_wdata)
               8'h26: if (w_st_eff == ST_IDLE) begin
                  w_nstate = ST_READY; w_rdata = ATQA_LO; w_err = 1'b0;
               end
               8'h52: if (w_st_eff == ST_IDLE || w_st_eff == ST_HALT) begin
                  w_nstate = ST_READY; w_rdata = ATQA_LO; w_err = 1'b0;
               end
               8'h93: if (w_st_eff == ST_READY && !w_sent_eff) begin
                  w_rdata = w_uid_eff[7:0]; w_nsent = 1'b1; w_nptr = 3'd1; w_err = 1'b0;
               end else if (w_st_eff == ST_READY) begin
                  w_nstate = ST_ACTIVE; w_rdata = SAK_VALUE; w_nsent = 1'b0; w_err = 1'b0;
               end
               8'h50: if (w_st_eff == ST_ACTIVE) begin
                  w_nstate = ST_HALT; w_rdata = 8'h00; w_err = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end
   // card tracking, irq pulse, command handshake and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_card_q   <= 1'b0;
         r_uid      <= '0;
         r_uid_sent <= 1'b0;
         r_rd_ptr   <= '0;
         r_irq_cnt  <= '0;
         r_busy     <= 1'b0;
         r_dly_cnt  <= '0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_done     <= 1'b0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_card_q   <= card_present;
         r_uid      <= w_uid_eff;
         r_uid_sent <= w_nsent;
         r_rd_ptr   <= w_nptr;
         r_irq_cnt  <= w_arrive ? 8'(IRQ_PULSE) : (w_remove || r_irq_cnt == 8'd0) ? 8'd0 : r_irq_cnt - 8'd1;
         r_done     <= w_fire;
         r_rdata    <= w_rdata;
         r_err      <= w_err;
         if (w_accept) begin
            r_busy    <= 1'b1;
            r_dly_cnt <= 8'(RESP_DELAY);
            r_write   <= nfc_cmd_write;
            r_addr    <= nfc_cmd_addr;
            r_wdata   <= nfc_cmd_wdata;
         end else if (w_fire) begin
            r_busy    <= 1'b0;
            r_dly_cnt <= 8'd0;
         end else if (r_busy) begin
            r_dly_cnt <= r_dly_cnt - 8'd1;
         end
      end
   end
endmodule
